// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and types for the DCT coefficient datapath.
//   BLK_N / BLK_PIX : block geometry (8x8 = 64 pixels)
//   COS_FRAC        : fractional bits of the cosine LUT values (Q8)
//   A_*             : normalisation multipliers in Q8 (0.5, 1/sqrt2, 1.0)
//   SCALE_SHIFT     : total right shift after the A multiply
//   dct_acc_state_t : accumulator FSM states
//   cos_t           : signed cosine LUT word
package dct_pkg;

   localparam int BLK_N    = 8;
   localparam int BLK_PIX  = 64;
   localparam int COS_FRAC = 8;

   localparam int A_DC_DC  = 128;   // both k1 and k2 are zero: 1/2
   localparam int A_DC_AC  = 181;   // exactly one of k1,k2 is zero: 1/sqrt(2)
   localparam int A_AC_AC  = 256;   // neither is zero: 1

   // 8 bits for A, 8 bits for the Q8 cosine, 2 bits for the 1/4 factor
   localparam int SCALE_SHIFT = 8 + COS_FRAC + 2;

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} dct_acc_state_t;

   typedef logic signed [31:0] cos_t;

   // Normalisation multiplier for a given (k1==0, k2==0) combination.
   function automatic int dct_scale_a(input bit k1z, input bit k2z);
      if (k1z && k2z)
         return A_DC_DC;
      else if (k1z || k2z)
         return A_DC_AC;
      else
         return A_AC_AC;
   endfunction

endpackage

// File: rtl/dct_coef_scale.sv
// dct_coef_scale: combinational DCT-II normalisation of an accumulator value.
//   coef = saturate((acc * A) >>> SCALE_SHIFT) to COEF_W signed bits,
//   where A depends on whether k1 and/or k2 are zero.
// Ports:
//   acc  in  ACC_W   signed accumulated sum of pixel * cos_term
//   coef out COEF_W  signed, saturated coefficient
module dct_coef_scale
   import dct_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int COEF_W  = 16,
   parameter int K1_ZERO = 0,
   parameter int K2_ZERO = 0
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [COEF_W-1:0] coef
);

   localparam int A_VAL = dct_scale_a(K1_ZERO != 0, K2_ZERO != 0);
   // A fits in 10 signed bits, so this product can never overflow
   localparam int MUL_W = ACC_W + 10;

   localparam logic signed [MUL_W-1:0] SAT_MAX =
      MUL_W'((longint'(1) <<< (COEF_W - 1)) - 1);
   localparam logic signed [MUL_W-1:0] SAT_MIN = -SAT_MAX - 1;

   logic signed [MUL_W-1:0] acc_ext;
   logic signed [MUL_W-1:0] a_ext;
   logic signed [MUL_W-1:0] shifted;

   assign acc_ext = MUL_W'(acc);
   assign a_ext   = MUL_W'(A_VAL);
   // arithmetic shift floors toward minus infinity for negative sums
   assign shifted = (acc_ext * a_ext) >>> SCALE_SHIFT;

   always_comb begin
      coef = shifted[COEF_W-1:0];
      if (shifted > SAT_MAX)
         coef = SAT_MAX[COEF_W-1:0];
      else if (shifted < SAT_MIN)
         coef = SAT_MIN[COEF_W-1:0];
   end

endmodule

// File: rtl/dct_coef_accum.sv
// dct_coef_accum: per-frequency consumer of one 2-D DCT cosine LUT.
// Accepts one 8x8 block in raster order, drives the LUT address from its
// own pixel counter, multiply-accumulates pixel * cos_term over 64 samples,
// normalises, and emits one signed coefficient over valid/ready.
// Build option: define DCT_LEVEL_SHIFT_EN to subtract 2^(PIX_W-1) from
// every pixel before the multiply (JPEG level shift).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   clear                           synchronous abort back to IDLE
//   pix_valid/pix_ready/pix_data    pixel stream
//   pix_last                        framing marker, checked against count
//   n1, n2                          LUT row/column of the next pixel
//   cos_term                        signed Q8 cosine for (n1,n2)
//   coef_valid/coef_ready/coef_data coefficient output
//   err_last                        sticky pix_last framing error
module dct_coef_accum
   import dct_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int ACC_W   = 32,
   parameter int COEF_W  = 16,
   parameter int K1_ZERO = 0,
   parameter int K2_ZERO = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [PIX_W-1:0]         pix_data,
   input  logic                     pix_last,
   output logic [2:0]               n1,
   output logic [2:0]               n2,
   input  cos_t                     cos_term,
   output logic                     coef_valid,
   input  logic                     coef_ready,
   output logic signed [COEF_W-1:0] coef_data,
   output logic                     err_last
);

   localparam logic [5:0] LAST_CNT = 6'(BLK_PIX - 1);

   dct_acc_state_t            state_reg;
   logic [5:0]                cnt_reg;
   logic signed [ACC_W-1:0]   acc_reg;
   logic                      coef_valid_reg;
   logic signed [COEF_W-1:0]  coef_data_reg;
   logic                      err_last_reg;

   logic signed [PIX_W:0]     pix_s;
   logic signed [ACC_W-1:0]   term;
   logic signed [COEF_W-1:0]  scaled;
   logic                      accept;
   logic                      cnt_last;

`ifdef DCT_LEVEL_SHIFT_EN
   localparam logic signed [PIX_W:0] PIX_MID = (PIX_W + 1)'(1 << (PIX_W - 1));
   assign pix_s = $signed({1'b0, pix_data}) - PIX_MID;
`else
   assign pix_s = $signed({1'b0, pix_data});
`endif

   // Only the low ACC_W bits of the product are kept, so multiplying at
   // ACC_W width gives the same result as a full-width product truncated.
   assign term = ACC_W'(pix_s) * ACC_W'(cos_term);

   assign n1         = cnt_reg[5:3];
   assign n2         = cnt_reg[2:0];
   assign pix_ready  = (state_reg == IDLE) || (state_reg == ACCUM);
   assign accept     = pix_valid && pix_ready && !clear;
   assign cnt_last   = (cnt_reg == LAST_CNT);
   assign coef_valid = coef_valid_reg;
   assign coef_data  = coef_data_reg;
   assign err_last   = err_last_reg;

   dct_coef_scale #(
      .ACC_W   (ACC_W),
      .COEF_W  (COEF_W),
      .K1_ZERO (K1_ZERO),
      .K2_ZERO (K2_ZERO)
   ) u_scale (
      .acc  (acc_reg),
      .coef (scaled)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         acc_reg        <= '0;
         coef_valid_reg <= 1'b0;
         coef_data_reg  <= '0;
         err_last_reg   <= 1'b0;
      end else if (clear) begin
         // err_last survives an abort so upstream framing faults stay visible
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         acc_reg        <= '0;
         coef_valid_reg <= 1'b0;
      end else begin
         // framing is checked but never steers the count
         if (accept && (pix_last != cnt_last))
            err_last_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  acc_reg   <= term;
                  cnt_reg   <= cnt_reg + 6'd1;
                  state_reg <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_reg <= acc_reg + term;
                  cnt_reg <= cnt_reg + 6'd1;   // wraps to 0 after pixel 63
                  if (cnt_last)
                     state_reg <= SCALE;
               end
            end
            SCALE: begin
               coef_data_reg  <= scaled;
               coef_valid_reg <= 1'b1;
               state_reg      <= OUT;
            end
            OUT: begin
               if (coef_ready) begin
                  coef_valid_reg <= 1'b0;
                  acc_reg        <= '0;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
